// File: rtl/offnariscv_pkg.sv
// Core-wide types for the offnariscv pipeline: stage bundles and FSM encodings.
package offnariscv_pkg;

    import riscv_pkg::*;

    localparam int EPOCH_W = 2;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [EPOCH_W-1:0] epoch;
    } pcgif_tdata_t;

    typedef enum logic [1:0] {
        RESET,
        BOOT,
        RUN
    } pcg_state_e;

endpackage

// File: rtl/riscv_pkg.sv
// Base RISC-V architectural parameters shared by the core.
package riscv_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream valid/ready channel with master and slave views.
interface axis_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/pc_generator.sv
// Fetch PC sequencer: issues PC+4 stream, applies committer redirects
// and tags beats with an epoch so younger stages can drop wrong-path work.
module pc_generator
    import riscv_pkg::*;
    import offnariscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000)
) (
    input  logic clk,
    input  logic rst,
    axis_if.s    wbpcg_axis_if,
    axis_if.m    pcgif_axis_if,
    output logic flush
);

    pcg_state_e state, next_state;

    logic [XLEN-1:0]    out_pc;
    logic [EPOCH_W-1:0] out_epoch;
    logic [XLEN-1:0]    next_pc;
    logic [EPOCH_W-1:0] epoch;
    logic               out_valid;

    logic               redir;
    logic               issue;
    logic [XLEN-1:0]    tgt;
    logic [XLEN-1:0]    base_pc;
    logic [EPOCH_W-1:0] epoch_nx;

    assign wbpcg_axis_if.tready = (state != RESET);
    assign pcgif_axis_if.tvalid = out_valid;
    assign pcgif_axis_if.tdata  = {out_pc, out_epoch};

    assign redir    = wbpcg_axis_if.tvalid && wbpcg_axis_if.tready;
    assign tgt      = wbpcg_axis_if.tdata & ~XLEN'(3);
    assign base_pc  = redir ? tgt : next_pc;
    assign epoch_nx = epoch + EPOCH_W'(redir);

    // BOOT loads the first beat internally, as if a handshake had happened
    assign issue = (state == BOOT) || (out_valid && pcgif_axis_if.tready);

    always_comb begin
        next_state = state;
        unique case (state)
            RESET:   next_state = BOOT;
            BOOT:    next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc    <= RESET_PC;
            out_epoch <= '0;
            next_pc   <= RESET_PC;
            epoch     <= '0;
            out_valid <= 1'b0;
            flush     <= 1'b0;
        end else begin
            epoch     <= epoch_nx;
            flush     <= redir;
            out_valid <= (state != RESET);
            if (issue) begin
                out_pc    <= base_pc;
                out_epoch <= epoch_nx;
                next_pc   <= base_pc + XLEN'(4);
            end else begin
                next_pc   <= base_pc;
            end
        end
    end

endmodule

// File: doc/pc_generator.md
# pc_generator

Program counter generator: the sequential front of the fetch pipeline and the consumer of the committer's redirect stream. Issues one fetch PC per handshake on an AXI-Stream master toward instruction fetch, advancing by 4. Accepts redirect targets (taken branches, trap/xRET/CSR new PCs) from the commit stage. Tags every issued PC with an epoch so downstream stages discard wrong-path instructions; pulses a flush on each redirect.

## Interface
Parameters:
- RESET_PC, default XLEN'('h8000_0000): first PC issued after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wbpcg_axis_if  axis_if.s  XLEN  redirect target from committer (tdata = new PC).
- pcgif_axis_if  axis_if.m  $bits(pcgif_tdata_t)  fetch request to instruction fetch (tdata = {pc, epoch}).
- flush  out  1  one-cycle pulse: kill all in-flight instructions with older epoch.

## Operation
- State machine: RESET (while rst), BOOT (one cycle after release), RUN.
- Registers: out_pc/out_epoch (driving pcgif tdata), next_pc, epoch, out_valid, flush, state.
- BOOT: pcgif tvalid=0; wbpcg tready=1; next_pc=RESET_PC unless a redirect arrives.
- RUN: pcgif tvalid=1 continuously; tdata held stable until handshake (AXIS rule; never replaced by a redirect).
- Fetch handshake (tvalid&&tready): out_pc<=next_pc, out_epoch<=epoch (post-redirect value if same cycle), next_pc<=next_pc+4.
- Redirect (wbpcg tvalid&&tready): epoch<=epoch+1; flush<=1 next cycle; next_pc<=target (handshake that cycle: beat issued is target, next_pc<=target+4).
- Pending stalled beat during redirect: stays presented with old epoch (downstream drops it); target follows after that handshake.
- Redirect beats +4 on same cycle; last redirect wins on back-to-back redirects (epoch increments each).
- wbpcg tready=1 in BOOT and RUN, 0 in RESET; committer relies on never being back-pressured after boot.
- Target bits [1:0] forced to 0 (IALIGN=32; misalignment trapped upstream).
- Arithmetic: PC +4 wraps modulo 2^XLEN; epoch wraps modulo 2^EPOCH_W.

## Timing
- Reset values: pcgif tvalid=0, tdata.pc=RESET_PC, tdata.epoch=0, flush=0, wbpcg tready=0, state=RESET.
- rst deassert edge E: BOOT during E+1 cycle; first beat (RESET_PC, epoch 0) valid from E+2.
- Redirect accepted cycle N: flush=1 only in N+1; with no stalled beat, tdata={target, epoch+1} in N+1.
- Throughput: one PC per cycle under continuous tready.
- rst mid-operation: all state returns to reset values immediately (async); any pending redirect lost.
- No combinational path from any input to pcgif tvalid/tdata or flush; wbpcg tready depends only on state.

## Structure
- offnariscv_pkg: pcgif_tdata_t {logic [XLEN-1:0] pc; logic [EPOCH_W-1:0] epoch;}, localparam EPOCH_W = 2, pcg_state_e {RESET, BOOT, RUN}.
- XLEN from riscv_pkg.
- Single module; no sub-module.

## Test plan
- Reset release, tready=1 -> beats 0x8000_0000, 0x8000_0004, 0x8000_0008 epoch 0 on consecutive cycles from E+2.
- Redirect 0x8000_0100 in cycle N with tready=1 -> flush=1 at N+1 only; beat {0x8000_0100, epoch 1}, then 0x8000_0104.
- tready=0 holding 0x8000_0008, redirect 0x8000_0200 -> 0x8000_0008 epoch 0 stays stable; after tready=1, next beat {0x8000_0200, epoch 1}.
- Redirects 0x100 then 0x200 back-to-back -> epoch +2, issued 0x200, flush high two cycles.
- Epoch 3 plus redirect -> epoch 0; PC 0xFFFF_FFFC +4 -> 0x0000_0000 (XLEN=32); target 0x8000_0103 -> issued 0x8000_0100.
- Assert rst while tvalid=1 and tready=0 -> tvalid=0, pc=RESET_PC, epoch=0 same cycle; restart per first scenario.
